sc_boot_ctrl: RTL
=================

Name: sc_boot_ctrl

Overview:
Boot/program-load sequencer for the single-cycle computer.
- Holds the CPU in reset after power-up.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses, then releases CPU reset.
- Sits between the board-level loader (UART/switch front end) and the cpu/imem pair. Drives the CPU reset input and the imem write port.

Parameters:
ADDR_W, 6, imem word-address width; depth = 2**ADDR_W words
TIMEOUT, 1000000, max clock cycles allowed between accepted bytes in LOAD before an error is flagged

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse; begin a load of load_len words
load_len  in  ADDR_W+1  number of words to load, sampled when load_start is accepted
run_req  in  1  single-cycle pulse; release CPU without loading
byte_valid  in  1  loader has a byte on byte_data
byte_data  in  8  stream byte
byte_ready  out  1  controller accepts byte this cycle
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  word to write
cpu_resetn  out  1  active-low reset to CPU, registered
busy  out  1  high in LOAD or WRITE
done  out  1  high in RUN
error  out  1  high in ERR

Behaviour:
- Reset (async, resetn=0):
  - Outputs: state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_resetn=0, busy=0, done=0, error=0.
  - Counters: byte_cnt=0, word_cnt=0, timer=0.
- States: IDLE, LOAD, WRITE, RUN, ERR. All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- IDLE (cpu_resetn=0):
  - load_start=1 → latch load_len and clear counters.
  - load_len=0 → RUN.
  - load_len > 2**ADDR_W → ERR.
  - Otherwise → LOAD.
  - run_req=1 (and no load_start) → RUN.
  - load_start has priority over run_req when both are asserted in the same cycle.
- LOAD: byte_ready=1.
  - A byte is accepted on byte_valid & byte_ready.
  - Byte k (k = byte_cnt, 0..3) goes into imem_wdata[8k+7:8k]; byte_cnt increments.
  - On the 4th accepted byte → WRITE next cycle; byte_cnt wraps to 0.
  - timer clears on each accepted byte and increments otherwise. timer reaching TIMEOUT-1 with no byte accepted → ERR.
  - load_start and run_req are ignored in LOAD.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word_cnt, imem_wdata holds the assembled word, byte_ready=0.
  - word_cnt == latched_len-1 → RUN; otherwise word_cnt+1 and → LOAD.
  - Latency: the 4th byte accepted at cycle N produces imem_we at cycle N+1. The last write at cycle M gives cpu_resetn=1 at cycle M+1.
- RUN: cpu_resetn=1, done=1.
  - load_start → same checks as IDLE. cpu_resetn drops to 0 in the next cycle, so the CPU is held in reset for the whole reload.
  - run_req is ignored.
- ERR: error=1, cpu_resetn=0, byte_ready=0.
  - load_start → restart as from IDLE; run_req → RUN.
- Boundaries:
  - byte_valid while byte_ready=0: no acceptance; the loader must hold the byte.
  - load_len == 2**ADDR_W: fills the full memory; imem_addr reaches 2**ADDR_W-1 and never wraps.
  - Async reset mid-load: all state is discarded and no partial word is written. imem contents already written are not cleared.
- Width rules:
  - word_cnt is ADDR_W bits; latched_len is ADDR_W+1 bits. Compare as unsigned with word_cnt zero-extended.
  - timer width is $clog2(TIMEOUT)+1.

Decomposition:
- Shared package sc_boot_pkg:
  - State encoding localparams (IDLE=0, LOAD=1, WRITE=2, RUN=3, ERR=4).
  - BYTES_PER_WORD=4.
- One natural sub-module: sc_byte_packer (byte_cnt, 4-byte little-endian shift/assemble, word_valid pulse).
- FSM, word counter and timer stay in sc_boot_ctrl.

Test Plan:
- Reset, then idle 10 cycles → cpu_resetn=0, byte_ready=0, done=0, imem_we never asserted.
- load_start with load_len=2; bytes 0x13,0x00,0x20,0x00,0xAA,0xBB,0xCC,0xDD → writes 0x00200013@0 then 0xDDCCBBAA@1. Each imem_we is 1 cycle after the 4th byte. cpu_resetn=1 and done=1 one cycle after the second write.
- Same load with byte_valid toggled randomly (50% duty) → identical writes; no byte dropped or duplicated.
- TIMEOUT=16; load_len=1; send 2 bytes then stop → error=1 and cpu_resetn=0 at the 16th idle cycle; no imem_we. A following load_start with a full 4 bytes → recovers to RUN.
- load_start and run_req in the same cycle from IDLE, load_len=0 → RUN next cycle. load_len=65 with ADDR_W=6 → ERR.
- In RUN, load_start with load_len=1 → cpu_resetn=0 next cycle, busy=1. resetn pulsed low after 2 bytes → all outputs return to reset values immediately, with no write.

Source files
------------

// File: rtl/sc_boot_pkg.sv
// Shared types and constants for the boot/program-load sequencer.
package sc_boot_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/sc_byte_packer.sv
// Assembles accepted stream bytes into a little-endian 32-bit word.
module sc_byte_packer
    import sc_boot_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q, word_d;
    logic                  last_byte;

    assign last_byte  = (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    // Strobes in the cycle the completing byte is accepted so the FSM can
    // enter WRITE on the same edge that stores the final byte.
    assign word_valid = accept && !clear && last_byte;
    assign word       = word_q;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/sc_boot_ctrl.sv
// Boot sequencer: holds the CPU in reset, streams words into imem, then
// releases the CPU.
module sc_boot_ctrl
    import sc_boot_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              run_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]    MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                byte_ready_q, imem_we_q, cpu_resetn_q;
    logic                busy_q, done_q, error_q;
    logic                accept, pk_clear, word_valid, last_word;
    logic [31:0]         word;

    function automatic state_t start_state(input logic [ADDR_W:0] len);
        if (len == '0)
            return ST_RUN;
        else if (len > MAX_LEN)
            return ST_ERR;
        else
            return ST_LOAD;
    endfunction

    assign accept    = byte_valid && byte_ready_q;
    assign last_word = ({1'b0, word_cnt_q} == len_q - (ADDR_W + 1)'(1));

    sc_byte_packer u_packer (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (pk_clear),
        .accept     (accept),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        pk_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_start) begin
                    len_d      = load_len;
                    word_cnt_d = '0;
                    timer_d    = '0;
                    pk_clear   = 1'b1;
                    state_d    = start_state(load_len);
                end else if (run_req && state_q != ST_RUN) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    timer_d = '0;
                    if (word_valid)
                        state_d = ST_WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_WRITE: begin
                timer_d = '0;
                if (last_word) begin
                    state_d = ST_RUN;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            timer_q      <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_resetn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            timer_q      <= timer_d;
            byte_ready_q <= (state_d == ST_LOAD);
            imem_we_q    <= (state_d == ST_WRITE);
            cpu_resetn_q <= (state_d == ST_RUN);
            busy_q       <= (state_d == ST_LOAD) || (state_d == ST_WRITE);
            done_q       <= (state_d == ST_RUN);
            error_q      <= (state_d == ST_ERR);
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = word_cnt_q;
    assign imem_wdata = word;
    assign cpu_resetn = cpu_resetn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
